// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, master states and CPOL/CPHA decoding.
package spi_pkg;

   typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_e;

   typedef enum logic {ST_IDLE, ST_SHIFT} spi_state_e;

   localparam int EDGES_PER_BYTE = 16;

   function automatic logic cpol(input spi_mode_e mode);
      return mode[1];
   endfunction

   function automatic logic cpha(input spi_mode_e mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side byte handshake plus SPI pins of the single-byte master.
interface spi_master_if;
   logic [7:0] tx_byte;
   logic       tx_dv;
   logic       tx_ready;
   logic       rx_dv;
   logic [7:0] rx_byte;
   logic       spi_clk;
   logic       spi_miso;
   logic       spi_mosi;

   modport master (
      input  tx_byte, tx_dv, spi_miso,
      output tx_ready, rx_dv, rx_byte, spi_clk, spi_mosi
   );

   modport slave (
      output tx_byte, tx_dv, spi_miso,
      input  tx_ready, rx_dv, rx_byte, spi_clk, spi_mosi
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: 16 edges per byte, one-cycle strobes marking leading/trailing edges.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic sclk,
   output logic lead,
   output logic trail,
   output logic busy
);

   localparam int            CW        = $clog2(2 * CLKS_PER_HALF_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLKS_PER_HALF_BIT - 1);
   localparam logic          CPOL      = cpol(spi_mode_e'(SPI_MODE));

   logic [CW-1:0] cnt;
   logic [4:0]    edges;

   assign busy = (edges != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         edges <= '0;
         sclk  <= CPOL;
         lead  <= 1'b0;
         trail <= 1'b0;
      end else begin
         lead  <= 1'b0;
         trail <= 1'b0;
         if (start) begin
            cnt   <= '0;
            edges <= 5'(EDGES_PER_BYTE);
         end else if (busy) begin
            // Full bit period: leading edge mid-count, trailing edge at wrap.
            if (cnt == FULL_LAST) begin
               cnt   <= '0;
               edges <= edges - 5'd1;
               trail <= 1'b1;
               sclk  <= ~sclk;
            end else if (cnt == HALF_LAST) begin
               cnt   <= cnt + 1'b1;
               edges <= edges - 5'd1;
               lead  <= 1'b1;
               sclk  <= ~sclk;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master; MSB first, no chip select.
module spi_master
   import spi_pkg::*;
#(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input logic          clk,
   input logic          rst_n,
   spi_master_if.master bus
);

   localparam logic CPHA = cpha(spi_mode_e'(SPI_MODE));

   spi_state_e state;
   logic       accept, lead, trail, busy, sclk;
   logic       drive_stb, sample_stb;
   logic [7:0] tx_sr, rx_sr;
   logic [3:0] tx_left, rx_left;

   assign accept     = (state == ST_IDLE) && bus.tx_ready && bus.tx_dv;
   assign drive_stb  = CPHA ? lead  : trail;
   assign sample_stb = CPHA ? trail : lead;
   assign bus.spi_clk = sclk;

   spi_sclk_gen #(
      .SPI_MODE          (SPI_MODE),
      .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
   ) u_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .sclk  (sclk),
      .lead  (lead),
      .trail (trail),
      .busy  (busy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         bus.tx_ready <= 1'b0;
         bus.rx_dv    <= 1'b0;
         bus.rx_byte  <= 8'h00;
         bus.spi_mosi <= 1'b0;
         tx_sr        <= 8'h00;
         rx_sr        <= 8'h00;
         tx_left      <= 4'd0;
         rx_left      <= 4'd0;
      end else begin
         bus.rx_dv <= 1'b0;
         case (state)
            ST_IDLE: begin
               bus.tx_ready <= 1'b1;
               if (accept) begin
                  state        <= ST_SHIFT;
                  bus.tx_ready <= 1'b0;
                  rx_left      <= 4'd8;
                  // CPHA=0 must present bit 7 before the first leading edge.
                  if (CPHA) begin
                     tx_sr   <= bus.tx_byte;
                     tx_left <= 4'd8;
                  end else begin
                     bus.spi_mosi <= bus.tx_byte[7];
                     tx_sr        <= {bus.tx_byte[6:0], 1'b0};
                     tx_left      <= 4'd7;
                  end
               end
            end
            ST_SHIFT: begin
               if (drive_stb && tx_left != 4'd0) begin
                  bus.spi_mosi <= tx_sr[7];
                  tx_sr        <= {tx_sr[6:0], 1'b0};
                  tx_left      <= tx_left - 4'd1;
               end
               if (sample_stb && rx_left != 4'd0) begin
                  rx_sr   <= {rx_sr[6:0], bus.spi_miso};
                  rx_left <= rx_left - 4'd1;
                  if (rx_left == 4'd1) begin
                     bus.rx_dv   <= 1'b1;
                     bus.rx_byte <= {rx_sr[6:0], bus.spi_miso};
                  end
               end
               if (!busy) begin
                  state        <= ST_IDLE;
                  bus.tx_ready <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// All four SPI modes run side by side on shared stimulus, each against a bit-level slave model.
module tb_spi_master;

   localparam int CPHB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       tx_dv, loopback, mon_clr;
   logic [7:0] tx_byte, slave_byte;
   logic [3:0] ready, rxdv, sclk, mosi;
   logic [7:0] rxb [4];
   logic [7:0] mon_mb [4];
   logic [7:0] mon_rb [4];
   int         mon_edges [4];
   int         mon_ndv [4];
   int         total = 0;
   int         bad = 0;

   for (genvar g = 0; g < 4; g++) begin : g_m
      localparam logic [1:0] MD   = 2'(g);
      localparam logic       CPOL = MD[1];
      localparam logic       CPHA = MD[0];

      spi_master_if u_if ();

      spi_master #(
         .SPI_MODE          (g),
         .CLKS_PER_HALF_BIT (CPHB)
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if.master)
      );

      logic       prev, slv_bit;
      int         edges, scnt, dcnt, sidx;
      int         ndv = 0;
      logic [7:0] mb, rb;

      assign u_if.tx_dv    = tx_dv;
      assign u_if.tx_byte  = tx_byte;
      assign u_if.spi_miso = loopback ? u_if.spi_mosi : slv_bit;
      assign ready[g]      = u_if.tx_ready;
      assign rxdv[g]       = u_if.rx_dv;
      assign sclk[g]       = u_if.spi_clk;
      assign mosi[g]       = u_if.spi_mosi;
      assign rxb[g]        = u_if.rx_byte;
      assign mon_mb[g]     = mb;
      assign mon_rb[g]     = rb;
      assign mon_edges[g]  = edges;
      assign mon_ndv[g]    = ndv;

      // Slave presents bit 7 first, then the next bit after each of its drive edges.
      always_comb begin
         sidx = CPHA ? 8 - dcnt : 7 - dcnt;
         if (sidx > 7) sidx = 7;
         if (sidx < 0) sidx = 0;
         slv_bit = slave_byte[sidx[2:0]];
      end

      always @(negedge clk) begin
         if (!rst_n) begin
            prev  = CPOL;
            edges = 0;
            scnt  = 0;
            dcnt  = 0;
         end else if (mon_clr) begin
            prev  = u_if.spi_clk;
            edges = 0;
            scnt  = 0;
            dcnt  = 0;
            ndv   = 0;
            mb    = 8'h00;
            rb    = 8'h00;
         end else begin
            if (u_if.spi_clk != prev) begin
               edges++;
               if (((edges % 2) == 1) != CPHA) begin
                  if (scnt < 8) mb[7-scnt] = u_if.spi_mosi;
                  scnt++;
               end else begin
                  dcnt++;
               end
            end
            prev = u_if.spi_clk;
            if (u_if.rx_dv) begin
               ndv++;
               rb = u_if.rx_byte;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      for (int m = 0; m < 4; m++) begin
         logic [1:0] mm;
         mm = 2'(m);
         chk($sformatf("%s_m%0d_ready", tag, m), ready[m], 0);
         chk($sformatf("%s_m%0d_rxdv", tag, m), rxdv[m], 0);
         chk($sformatf("%s_m%0d_rxbyte", tag, m), rxb[m], 0);
         chk($sformatf("%s_m%0d_sclk", tag, m), sclk[m], mm[1]);
         chk($sformatf("%s_m%0d_mosi", tag, m), mosi[m], 0);
      end
   endtask

   // Called at negedge+1 with all modes idle and ready.
   task automatic start_xfer(input logic [7:0] b, input logic [7:0] sb, input logic lb,
                             input int hold);
      tx_byte    = b;
      slave_byte = sb;
      loopback   = lb;
      tx_dv      = 1'b1;
      mon_clr    = 1'b1;
      @(negedge clk); #1;
      mon_clr = 1'b0;
      repeat (hold - 1) begin
         @(negedge clk); #1;
      end
      tx_dv = 1'b0;
   endtask

   task automatic finish_xfer(input logic [7:0] b, input logic [7:0] sb, input logic lb);
      int n;
      logic [7:0] exp_rx;
      n = 0;
      exp_rx = lb ? b : sb;
      while (ready != 4'hF && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("xfer_timeout", 32'(n < 200), 1);
      for (int m = 0; m < 4; m++) begin
         logic [1:0] mm;
         mm = 2'(m);
         chk($sformatf("m%0d_rx_at_dv %0h", m, b), mon_rb[m], exp_rx);
         chk($sformatf("m%0d_rx_hold %0h", m, b), rxb[m], exp_rx);
         chk($sformatf("m%0d_mosi_bits %0h", m, b), mon_mb[m], b);
         chk($sformatf("m%0d_edges %0h", m, b), mon_edges[m], 16);
         chk($sformatf("m%0d_rxdv_cnt %0h", m, b), mon_ndv[m], 1);
         chk($sformatf("m%0d_sclk_idle", m), sclk[m], mm[1]);
         chk($sformatf("m%0d_mosi_last", m), mosi[m], b[0]);
      end
   endtask

   task automatic run_xfer(input logic [7:0] b, input logic [7:0] sb, input logic lb,
                           input int hold);
      start_xfer(b, sb, lb, hold);
      finish_xfer(b, sb, lb);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      logic [7:0] b, sb;
      tx_dv      = 1'b0;
      tx_byte    = 8'h00;
      slave_byte = 8'h00;
      loopback   = 1'b1;
      mon_clr    = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check_reset("por");
      rst_n = 1'b1;
      for (int m = 0; m < 4; m++) chk($sformatf("m%0d_ready_at_release", m), ready[m], 0);
      @(posedge clk); #1;
      for (int m = 0; m < 4; m++) chk($sformatf("m%0d_ready_after_release", m), ready[m], 1);
      @(negedge clk); #1;

      run_xfer(8'hAA, 8'h00, 1'b1, 1);
      run_xfer(8'h5A, 8'h00, 1'b1, 1);
      run_xfer(8'hFF, 8'h00, 1'b1, 1);
      run_xfer(8'hC3, 8'h96, 1'b0, 2);
      // Back-to-back: second request lands on the first ready cycle.
      run_xfer(8'h81, 8'h42, 1'b0, 1);
      run_xfer(8'h7E, 8'hBD, 1'b0, 1);

      start_xfer(8'h96, 8'h69, 1'b0, 1);
      n = 0;
      while (mon_edges[0] < 4 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk("abort_wait", 32'(n < 100), 1);
      #2 rst_n = 1'b0;
      #1 check_reset("abort");
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int m = 0; m < 4; m++) chk($sformatf("m%0d_ready_after_abort", m), ready[m], 1);
      repeat (40) @(negedge clk);
      #1;
      for (int m = 0; m < 4; m++) begin
         chk($sformatf("m%0d_no_rxdv_after_abort", m), mon_ndv[m], 0);
         chk($sformatf("m%0d_no_edges_after_abort", m), mon_edges[m], 0);
      end
      run_xfer(8'h3C, 8'hA5, 1'b1, 1);

      for (int i = 0; i < 24; i++) begin
         b  = 8'($urandom);
         sb = 8'($urandom);
         run_xfer(b, sb, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk); #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
